network_bf_out: RTL and testbench
=================================

# network_bf_out

Write-back crossbar for the CFNTT datapath. It takes the four results of the two butterfly units (x0, y0, x1, y1) and steers each one to the write port of one of the four coefficient memory banks. The bank selects and write addresses are captured when the operands are read. They travel through a delay pipeline matched to the butterfly latency, so each write lands in the bank and address that the read side decided on. The block sits between the butterfly pair and the bank write ports, in the write direction of the four-bank memory.

## Interface
Parameters:
- data_width, 14, coefficient width
- addr_width, 6, bank address width
- bf_latency, 4, cycles from control capture (in_valid) to butterfly result arrival; legal range ≥1

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  control for one butterfly-pair operation is presented this cycle
- sel_b_0..sel_b_3  input  2 each  destination bank for lanes x0, y0, x1, y1; 00=bank0 … 11=bank3
- addr_b_0..addr_b_3  input  addr_width each  write address for lanes x0, y0, x1, y1
- x0, y0, x1, y1  input  data_width each  butterfly results; valid exactly bf_latency cycles after the matching in_valid
- d0..d3  output  data_width each  bank write data, registered
- waddr0..waddr3  output  addr_width each  bank write address, registered
- wen0..wen3  output  1 each  bank write enable, registered
- busy  output  1  at least one operation is in flight in the delay pipeline or the output register
- conflict  output  1  sticky collision flag; present only with the configuration macro, otherwise tied 0

## Operation
- Delay pipeline: bf_latency stages of {valid, sel_b_0..3, addr_b_0..3}, shifting every cycle with no stall. Stage 0 loads in_valid plus the controls.
- The pipeline accepts back-to-back in_valid, one operation per cycle, with no bubbles.
- Lane ordering: x0 (lane 0), y0 (lane 1), x1 (lane 2), y1 (lane 3).
- Routing at the pipeline tail, when the tail valid is 1:
  - For each lane L, bank sel_b_L receives data L and address addr_b_L.
  - wen for that bank is set to 1.
  - The output register captures the result.
- Priority: if several lanes target the same bank, the highest-index lane wins (lane 3 > 2 > 1 > 0). Losing lanes are dropped.
- Tail valid = 0: all wenN are 0 in the next cycle. d/waddr hold their previous values (don't-care to consumers).
- Banks that no lane targets get wenN = 0 for that operation.
- busy = OR of all pipeline valid bits and any wenN.
- Reset: every output is 0 (d, waddr, wen, busy, conflict) and all pipeline valid bits are cleared. Sel/addr stage contents are don't-care.
- Reset mid-operation: every in-flight operation is discarded and produces no write. The first in_valid after rst deasserts behaves like a fresh start.

## Timing
- in_valid at cycle t → butterfly data sampled at cycle t+bf_latency → wen/d/waddr visible at cycle t+bf_latency+1.
- Total control-to-write latency is bf_latency+1.
- Throughput: one operation (four writes) per cycle.
- Data is sampled only on the tail-valid cycle. x/y values in other cycles have no effect.
- in_valid asserted in the same cycle as rst is ignored.
- busy rises the cycle after in_valid. It falls in the cycle after the last wen pulse.

## Configuration
- Macro: NETWORK_BF_OUT_CONFLICT_CHK_EN.
- Defined:
  - The block compares the four tail selects pairwise.
  - Any equal pair while tail valid = 1 sets conflict in the same cycle that the write is registered.
  - conflict stays 1 until rst. Priority routing is unchanged.
- Undefined:
  - No comparator logic is built and conflict is constant 0.
  - Routing and priority are identical to the defined case.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1 → all outputs 0, busy = 0, and no wen pulse during the following bf_latency+1 cycles.
- Identity mapping:
  - Stimulus: sel = 0,1,2,3, addr = 5,6,7,8, x0/y0/x1/y1 = 0x0011/0x0022/0x0033/0x0044 (bf_latency = 4).
  - Response: at t+5, wen0..3 = 1, d0..d3 = 0x0011..0x0044, waddr0..3 = 5..8.
- Permuted, back-to-back:
  - Stimulus: cycle t uses sel = 3,2,1,0; cycle t+1 uses sel = 1,0,3,2; each with distinct data.
  - Response: writes appear on consecutive cycles t+5 and t+6 with correctly permuted data/address, and busy stays 1 throughout both.
- Collision:
  - Stimulus: sel = 2,2,2,1 with data A, B, C, D.
  - Response: d2 = C, d1 = D, wen = 0110.
  - With NETWORK_BF_OUT_CONFLICT_CHK_EN: conflict = 1 and stays 1 until rst.
  - Without the macro: conflict = 0.
- Reset mid-flight: in_valid at t, then rst at t+2 → no wen pulses at t+5, and busy = 0 from t+3.
- Idle gap: in_valid at t, nothing else → exactly one write cycle at t+5, and wen = 0 on every other cycle.

Source files
------------

// File: rtl/network_bf_out.sv
// Write-back crossbar: delays bank selects/addresses by bf_latency and steers the
// four butterfly results to the bank write ports. Optional collision flag: NETWORK_BF_OUT_CONFLICT_CHK_EN.
module network_bf_out #(
  parameter int unsigned data_width = 14,
  parameter int unsigned addr_width = 6,
  parameter int unsigned bf_latency = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [1:0]            sel_b_0,
  input  logic [1:0]            sel_b_1,
  input  logic [1:0]            sel_b_2,
  input  logic [1:0]            sel_b_3,
  input  logic [addr_width-1:0] addr_b_0,
  input  logic [addr_width-1:0] addr_b_1,
  input  logic [addr_width-1:0] addr_b_2,
  input  logic [addr_width-1:0] addr_b_3,
  input  logic [data_width-1:0] x0,
  input  logic [data_width-1:0] y0,
  input  logic [data_width-1:0] x1,
  input  logic [data_width-1:0] y1,
  output logic [data_width-1:0] d0,
  output logic [data_width-1:0] d1,
  output logic [data_width-1:0] d2,
  output logic [data_width-1:0] d3,
  output logic [addr_width-1:0] waddr0,
  output logic [addr_width-1:0] waddr1,
  output logic [addr_width-1:0] waddr2,
  output logic [addr_width-1:0] waddr3,
  output logic                  wen0,
  output logic                  wen1,
  output logic                  wen2,
  output logic                  wen3,
  output logic                  busy,
  output logic                  conflict
);

  localparam int unsigned NumLanes = 4;
  localparam int unsigned Tail     = bf_latency - 1;

  logic [1:0]            sel_in  [NumLanes];
  logic [addr_width-1:0] addr_in [NumLanes];
  logic [data_width-1:0] lane_data [NumLanes];

  logic [bf_latency-1:0] vld_q, vld_d;
  logic [1:0]            sel_q  [bf_latency][NumLanes];
  logic [addr_width-1:0] addr_q [bf_latency][NumLanes];

  logic [data_width-1:0] d_q [NumLanes], d_d [NumLanes];
  logic [addr_width-1:0] waddr_q [NumLanes], waddr_d [NumLanes];
  logic [NumLanes-1:0]   wen_q, wen_d;
  logic                  busy_q, busy_d;

  assign sel_in    = '{sel_b_0, sel_b_1, sel_b_2, sel_b_3};
  assign addr_in   = '{addr_b_0, addr_b_1, addr_b_2, addr_b_3};
  assign lane_data = '{x0, y0, x1, y1};

  // Next-state: valid shift, priority routing (later lanes overwrite earlier ones), busy.
  always_comb begin
    vld_d    = '0;
    wen_d    = '0;
    d_d      = d_q;
    waddr_d  = waddr_q;
    vld_d[0] = in_valid;
    for (int i = 1; i < int'(bf_latency); i++) begin
      vld_d[i] = vld_q[i-1];
    end
    if (vld_q[Tail]) begin
      for (int l = 0; l < int'(NumLanes); l++) begin
        wen_d[sel_q[Tail][l]]   = 1'b1;
        d_d[sel_q[Tail][l]]     = lane_data[l];
        waddr_d[sel_q[Tail][l]] = addr_q[Tail][l];
      end
    end
    busy_d = (|vld_d) | (|wen_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      wen_q   <= '0;
      busy_q  <= 1'b0;
      d_q     <= '{default: '0};
      waddr_q <= '{default: '0};
    end else begin
      vld_q   <= vld_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      d_q     <= d_d;
      waddr_q <= waddr_d;
    end
  end

  // Control payload pipeline; contents only matter where the valid bit is set.
  always_ff @(posedge clk) begin
    sel_q[0]  <= sel_in;
    addr_q[0] <= addr_in;
    for (int i = 1; i < int'(bf_latency); i++) begin
      sel_q[i]  <= sel_q[i-1];
      addr_q[i] <= addr_q[i-1];
    end
  end

`ifdef NETWORK_BF_OUT_CONFLICT_CHK_EN
  logic conflict_q, conflict_d;
  logic pair_eq_c;

  always_comb begin
    pair_eq_c = (sel_q[Tail][0] == sel_q[Tail][1]) | (sel_q[Tail][0] == sel_q[Tail][2]) |
                (sel_q[Tail][0] == sel_q[Tail][3]) | (sel_q[Tail][1] == sel_q[Tail][2]) |
                (sel_q[Tail][1] == sel_q[Tail][3]) | (sel_q[Tail][2] == sel_q[Tail][3]);
    conflict_d = conflict_q | (vld_q[Tail] & pair_eq_c);
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_q <= 1'b0;
    else     conflict_q <= conflict_d;
  end

  assign conflict = conflict_q;
`else
  assign conflict = 1'b0;
`endif

  assign d0     = d_q[0];
  assign d1     = d_q[1];
  assign d2     = d_q[2];
  assign d3     = d_q[3];
  assign waddr0 = waddr_q[0];
  assign waddr1 = waddr_q[1];
  assign waddr2 = waddr_q[2];
  assign waddr3 = waddr_q[3];
  assign wen0   = wen_q[0];
  assign wen1   = wen_q[1];
  assign wen2   = wen_q[2];
  assign wen3   = wen_q[3];
  assign busy   = busy_q;

endmodule

// File: tb/tb_network_bf_out.sv
// Scoreboard bench for network_bf_out: directed operations push hand-computed writes,
// a negedge monitor pops them at the expected cycle and requires wen=0 elsewhere.
module tb_network_bf_out;
  localparam int unsigned DW  = 14;
  localparam int unsigned AW  = 6;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst, in_valid;
  logic [1:0]    sel_b_0, sel_b_1, sel_b_2, sel_b_3;
  logic [AW-1:0] addr_b_0, addr_b_1, addr_b_2, addr_b_3;
  logic [DW-1:0] x0, y0, x1, y1;
  logic [DW-1:0] d0, d1, d2, d3;
  logic [AW-1:0] waddr0, waddr1, waddr2, waddr3;
  logic wen0, wen1, wen2, wen3, busy, conflict;

  network_bf_out #(.data_width(DW), .addr_width(AW), .bf_latency(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .sel_b_0(sel_b_0), .sel_b_1(sel_b_1), .sel_b_2(sel_b_2), .sel_b_3(sel_b_3),
    .addr_b_0(addr_b_0), .addr_b_1(addr_b_1), .addr_b_2(addr_b_2), .addr_b_3(addr_b_3),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2), .waddr3(waddr3),
    .wen0(wen0), .wen1(wen1), .wen2(wen2), .wen3(wen3),
    .busy(busy), .conflict(conflict)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int              cyc;
    logic [3:0]      wen;
    logic [3:0][DW-1:0] d;
    logic [3:0][AW-1:0] a;
  } exp_t;

  exp_t sb[$];
  logic [3:0][DW-1:0] data_at [int];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;

  // stimulus / expectation staging (lane order x0,y0,x1,y1; bank order 0..3)
  logic [1:0]    s_v [4];
  logic [AW-1:0] ad_v [4];
  logic [DW-1:0] dt_v [4];
  logic [3:0]    ew_v;
  logic [DW-1:0] ed_v [4];
  logic [AW-1:0] ea_v [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drive butterfly results only in the scheduled cycle; junk otherwise.
  always @(negedge clk) begin
    if (data_at.exists(cyc)) begin
      x0 = data_at[cyc][0]; y0 = data_at[cyc][1];
      x1 = data_at[cyc][2]; y1 = data_at[cyc][3];
    end else begin
      x0 = DW'($urandom); y0 = DW'($urandom);
      x1 = DW'($urandom); y1 = DW'($urandom);
    end
  end

  // Monitor: compare scheduled writes, otherwise require no write enable.
  always @(negedge clk) begin
    logic [DW-1:0] dq [4];
    logic [AW-1:0] aq [4];
    exp_t e;
    if (mon_en) begin
      dq = '{d0, d1, d2, d3};
      aq = '{waddr0, waddr1, waddr2, waddr3};
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check("wen", 32'({wen3, wen2, wen1, wen0}), 32'(e.wen));
        for (int b = 0; b < 4; b++) begin
          if (e.wen[b]) begin
            check($sformatf("d%0d", b), 32'(dq[b]), 32'(e.d[b]));
            check($sformatf("waddr%0d", b), 32'(aq[b]), 32'(e.a[b]));
          end
        end
      end else begin
        check("idle_wen", 32'({wen3, wen2, wen1, wen0}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Present one operation in the current cycle; optionally schedule its expected write.
  task automatic issue(input logic push);
    exp_t e;
    logic [3:0][DW-1:0] dd;
    in_valid = 1'b1;
    sel_b_0 = s_v[0];  sel_b_1 = s_v[1];  sel_b_2 = s_v[2];  sel_b_3 = s_v[3];
    addr_b_0 = ad_v[0]; addr_b_1 = ad_v[1]; addr_b_2 = ad_v[2]; addr_b_3 = ad_v[3];
    for (int l = 0; l < 4; l++) dd[l] = dt_v[l];
    data_at[cyc + int'(LAT)] = dd;
    if (push) begin
      e.cyc = cyc + int'(LAT) + 1;
      e.wen = ew_v;
      for (int b = 0; b < 4; b++) begin
        e.d[b] = ed_v[b];
        e.a[b] = ea_v[b];
      end
      sb.push_back(e);
    end
  endtask

  initial begin
    int c;
    logic exp_conf;
`ifdef NETWORK_BF_OUT_CONFLICT_CHK_EN
    exp_conf = 1'b1;
`else
    exp_conf = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b1;
    sel_b_0 = 2'd0; sel_b_1 = 2'd1; sel_b_2 = 2'd2; sel_b_3 = 2'd3;
    addr_b_0 = '0; addr_b_1 = '0; addr_b_2 = '0; addr_b_3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wen", 32'({wen3, wen2, wen1, wen0}), 32'd0);
    check("rst_d", 32'(d0 | d1 | d2 | d3), 32'd0);
    check("rst_waddr", 32'(waddr0 | waddr1 | waddr2 | waddr3), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_conflict", 32'(conflict), 32'd0);
    rst = 1'b0; in_valid = 1'b0; mon_en = 1'b1;
    repeat (LAT + 3) tick();

    // identity mapping
    tick();
    s_v = '{2'd0, 2'd1, 2'd2, 2'd3}; ad_v = '{6'd5, 6'd6, 6'd7, 6'd8};
    dt_v = '{14'h0011, 14'h0022, 14'h0033, 14'h0044};
    ew_v = 4'b1111; ed_v = '{14'h0011, 14'h0022, 14'h0033, 14'h0044};
    ea_v = '{6'd5, 6'd6, 6'd7, 6'd8};
    issue(1'b1);
    repeat (LAT + 3) tick();

    // permuted, back to back
    tick();
    c = cyc;
    s_v = '{2'd3, 2'd2, 2'd1, 2'd0}; ad_v = '{6'd10, 6'd11, 6'd12, 6'd13};
    dt_v = '{14'h0101, 14'h0102, 14'h0103, 14'h0104};
    ew_v = 4'b1111; ed_v = '{14'h0104, 14'h0103, 14'h0102, 14'h0101};
    ea_v = '{6'd13, 6'd12, 6'd11, 6'd10};
    issue(1'b1);
    tick();
    s_v = '{2'd1, 2'd0, 2'd3, 2'd2}; ad_v = '{6'd20, 6'd21, 6'd22, 6'd23};
    dt_v = '{14'h0201, 14'h0202, 14'h0203, 14'h0204};
    ew_v = 4'b1111; ed_v = '{14'h0202, 14'h0201, 14'h0204, 14'h0203};
    ea_v = '{6'd21, 6'd20, 6'd23, 6'd22};
    issue(1'b1);
    check("b2b_busy", 32'(busy), 32'd1);
    while (cyc < c + int'(LAT) + 3) begin
      tick();
      check("b2b_busy", 32'(busy), (cyc <= c + int'(LAT) + 2) ? 32'd1 : 32'd0);
    end
    check("pre_conflict", 32'(conflict), 32'd0);

    // collision: lanes 0..2 on bank2, lane3 on bank1
    tick();
    s_v = '{2'd2, 2'd2, 2'd2, 2'd1}; ad_v = '{6'd30, 6'd31, 6'd32, 6'd33};
    dt_v = '{14'h0AAA, 14'h0BBB, 14'h0CCC, 14'h0DDD};
    ew_v = 4'b0110; ed_v = '{14'h0000, 14'h0DDD, 14'h0CCC, 14'h0000};
    ea_v = '{6'd0, 6'd33, 6'd32, 6'd0};
    issue(1'b1);
    repeat (LAT + 1) tick();
    check("conflict", 32'(conflict), 32'(exp_conf));
    repeat (4) tick();
    check("conflict_sticky", 32'(conflict), 32'(exp_conf));

    // idle gap: single op, every other cycle must be write-free
    tick();
    s_v = '{2'd3, 2'd0, 2'd1, 2'd2}; ad_v = '{6'd40, 6'd41, 6'd42, 6'd43};
    dt_v = '{14'h1401, 14'h1402, 14'h1403, 14'h1404};
    ew_v = 4'b1111; ed_v = '{14'h1402, 14'h1403, 14'h1404, 14'h1401};
    ea_v = '{6'd41, 6'd42, 6'd43, 6'd40};
    issue(1'b1);
    repeat (LAT + 5) tick();

    // reset mid-flight: operation must vanish
    tick();
    c = cyc;
    s_v = '{2'd0, 2'd1, 2'd2, 2'd3}; ad_v = '{6'd50, 6'd51, 6'd52, 6'd53};
    dt_v = '{14'h2001, 14'h2002, 14'h2003, 14'h2004};
    issue(1'b0);
    tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy_post", 32'(busy), 32'd0);
    check("mid_conflict_clr", 32'(conflict), 32'd0);
    while (cyc < c + int'(LAT) + 4) begin
      tick();
      check("mid_busy_idle", 32'(busy), 32'd0);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
